// File: rtl/jtframe_rom_arb_if.sv
// Bus bundle for jtframe_rom_arb: the four ROM slot ports on one side and
// the frame's single SDRAM read port on the other.
// master = the arbiter's view, slave = the surrounding game/frame logic.
interface jtframe_rom_arb_if #(
  parameter int AW = 22
);
  logic            downloading;
  logic [3:0]      slot_req;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]      slot_ok;
  logic [127:0]    slot_dout;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            data_rdy;
  logic [31:0]     data_read;
  logic            refresh_en;

  modport master (
    input  downloading, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );

  modport slave (
    output downloading, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
  );
endinterface

// File: rtl/jtframe_rom_arb.sv
// Four-slot SDRAM read arbiter with a one-word cache per slot.
// Hits are served from the cache; misses are queued onto the single SDRAM
// read port, round-robin by default.
// Build option: define JTFRAME_ROM_ARB_PRIO_EN for fixed priority
// (slot 0 highest, slot 3 lowest; slot 3 may starve).
module jtframe_rom_arb #(
  parameter int            AW           = 22,
  parameter logic [AW-1:0] SLOT0_OFFSET = {AW{1'b0}},
  parameter logic [AW-1:0] SLOT1_OFFSET = {AW{1'b0}},
  parameter logic [AW-1:0] SLOT2_OFFSET = {AW{1'b0}},
  parameter logic [AW-1:0] SLOT3_OFFSET = {AW{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  jtframe_rom_arb_if.master bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    sel_r;
  logic [AW-1:0] lat_addr_r;
  logic [AW-1:0] sdram_addr_r;
  logic          sdram_req_r;
  logic          refresh_en_r;
  logic          discard_r;
  logic [3:0]    valid_r;
  logic [127:0]  slot_dout_r;
  logic [AW-1:0] cached_addr_r [4];
`ifndef JTFRAME_ROM_ARB_PRIO_EN
  logic [1:0]    last_grant_r;
  logic [1:0]    idx_s;
`endif

  logic [3:0]    hit_s;
  logic [3:0]    pend_s;
  logic          grant_vld_s;
  logic [1:0]    grant_sel_s;
  logic [AW-1:0] grant_addr_s;
  logic          store_s;

  function automatic logic [AW-1:0] slot_offset(input logic [1:0] s);
    case (s)
      2'd0:    slot_offset = SLOT0_OFFSET;
      2'd1:    slot_offset = SLOT1_OFFSET;
      2'd2:    slot_offset = SLOT2_OFFSET;
      2'd3:    slot_offset = SLOT3_OFFSET;
      default: slot_offset = {AW{1'b0}};
    endcase
  endfunction

  // A slot hits when its cached word belongs to the address it shows now.
  always_comb begin
    hit_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      hit_s[i] = valid_r[i] & (cached_addr_r[i] == bus.slot_addr[i*AW +: AW]);
    end
  end

  assign pend_s       = bus.slot_req & ~hit_s;
  assign grant_addr_s = bus.slot_addr[grant_sel_s*AW +: AW];
  assign store_s      = bus.data_rdy & ((state_r == WAIT_DATA) |
                                        ((state_r == WAIT_ACK) & bus.sdram_ack));

`ifdef JTFRAME_ROM_ARB_PRIO_EN
  // Fixed priority pick: the lowest-numbered pending slot wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_sel_s = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pend_s[k]) begin
        grant_vld_s = 1'b1;
        grant_sel_s = 2'(k);
      end else begin
        grant_vld_s = grant_vld_s;
        grant_sel_s = grant_sel_s;
      end
    end
  end
`else
  // Round-robin pick: first pending slot after the last granted one.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_sel_s = 2'd0;
    idx_s       = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx_s = last_grant_r + 2'(k);
      if (pend_s[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_sel_s = idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
        grant_sel_s = grant_sel_s;
      end
    end
  end
`endif

  // Request sequencer: grant, wait for ack, wait for data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      sel_r        <= 2'd0;
      lat_addr_r   <= {AW{1'b0}};
      sdram_addr_r <= {AW{1'b0}};
      sdram_req_r  <= 1'b0;
      refresh_en_r <= 1'b0;
      discard_r    <= 1'b0;
`ifndef JTFRAME_ROM_ARB_PRIO_EN
      last_grant_r <= 2'd3;
`endif
    end else begin
      refresh_en_r <= (state_r == IDLE) && (pend_s == 4'b0000);
      case (state_r)
        IDLE: begin
          if (grant_vld_s && !bus.downloading) begin
            sel_r        <= grant_sel_s;
            lat_addr_r   <= grant_addr_s;
            sdram_addr_r <= grant_addr_s + slot_offset(grant_sel_s);
            sdram_req_r  <= 1'b1;
            discard_r    <= 1'b0;
`ifndef JTFRAME_ROM_ARB_PRIO_EN
            last_grant_r <= grant_sel_s;
`endif
            state_r      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.downloading) discard_r <= 1'b1;
          if (bus.sdram_ack) begin
            sdram_req_r <= 1'b0;
            // ack and data together: the access is already complete
            state_r     <= bus.data_rdy ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (bus.downloading) discard_r <= 1'b1;
          if (bus.data_rdy) state_r <= IDLE;
        end
        default: begin
          sdram_req_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Cache update: the word is always kept under the latched address, but only
  // marked valid when no download overlapped the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r     <= 4'b0000;
      slot_dout_r <= 128'd0;
      for (int i = 0; i < 4; i++) cached_addr_r[i] <= {AW{1'b0}};
    end else begin
      if (store_s) begin
        slot_dout_r[sel_r*32 +: 32] <= bus.data_read;
        cached_addr_r[sel_r]        <= lat_addr_r;
        valid_r[sel_r]              <= ~discard_r;
      end
      if (bus.downloading) valid_r <= 4'b0000;
    end
  end

  assign bus.slot_ok    = hit_s;
  assign bus.slot_dout  = slot_dout_r;
  assign bus.sdram_req  = sdram_req_r;
  assign bus.sdram_addr = sdram_addr_r;
  assign bus.refresh_en = refresh_en_r;

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed testbench for jtframe_rom_arb. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_jtframe_rom_arb;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  jtframe_rom_arb_if #(.AW(AW)) bus ();

  jtframe_rom_arb #(
    .AW          (AW),
    .SLOT0_OFFSET(22'h0),
    .SLOT1_OFFSET(22'h0),
    .SLOT2_OFFSET(22'h20000),
    .SLOT3_OFFSET(22'h100000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Wait (bounded) for the arbiter to raise sdram_req.
  task automatic wait_req(output logic got);
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      if (bus.sdram_req) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Answer the outstanding request: ack pulse, then data pulse.
  task automatic respond(input logic [31:0] d);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b1;
    bus.data_read = d;
    @(negedge clk);
    bus.data_rdy  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.slot_ok !== 4'b0000 || bus.sdram_req !== 1'b0 || bus.refresh_en !== 1'b0 ||
        bus.sdram_addr !== 22'h0 || bus.slot_dout !== 128'd0) begin
      n_err++;
      $display("FAIL reset_values: ok=%b req=%b ref=%b addr=%h dout=%h, required 0/0/0/0/0",
               bus.slot_ok, bus.sdram_req, bus.refresh_en, bus.sdram_addr, bus.slot_dout);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.refresh_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_refresh: refresh_en=%b, required 1", bus.refresh_en);
    end
  endtask

  task automatic test_basic;
    bus.slot_addr[0*AW +: AW] = 22'h100;
    bus.slot_req = 4'b0001;
    n_vec++;
    if (bus.sdram_req !== 1'b0) begin
      n_err++;
      $display("FAIL basic_no_early_req: sdram_req=%b, required 0", bus.sdram_req);
    end
    @(negedge clk);
    n_vec++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h100) begin
      n_err++;
      $display("FAIL basic_grant: req=%b addr=%h, required 1/100", bus.sdram_req, bus.sdram_addr);
    end
    respond(32'hDEADBEEF);
    n_vec++;
    if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[31:0] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL basic_data: ok0=%b dout0=%h, required 1/deadbeef",
               bus.slot_ok[0], bus.slot_dout[31:0]);
    end
    bus.slot_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_hit;
    logic got;
    bus.slot_req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.sdram_req !== 1'b0 || bus.slot_ok[0] !== 1'b1) begin
        n_err++;
        $display("FAIL hit_no_traffic: req=%b ok0=%b, required 0/1", bus.sdram_req, bus.slot_ok[0]);
      end
    end
    n_vec++;
    if (bus.refresh_en !== 1'b1) begin
      n_err++;
      $display("FAIL hit_refresh: refresh_en=%b, required 1", bus.refresh_en);
    end
    bus.slot_addr[0*AW +: AW] = 22'h101;
    #1;
    n_vec++;
    if (bus.slot_ok[0] !== 1'b0) begin
      n_err++;
      $display("FAIL hit_addr_change: ok0=%b, required 0", bus.slot_ok[0]);
    end
    wait_req(got);
    n_vec++;
    if (!got || bus.sdram_addr !== 22'h101) begin
      n_err++;
      $display("FAIL hit_remiss_req: got=%b addr=%h, required 1/101", got, bus.sdram_addr);
    end
    if (got) respond(32'h01010101);
    n_vec++;
    if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[31:0] !== 32'h01010101) begin
      n_err++;
      $display("FAIL hit_remiss_data: ok0=%b dout0=%h, required 1/01010101",
               bus.slot_ok[0], bus.slot_dout[31:0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.sdram_req !== 1'b0) begin
        n_err++;
        $display("FAIL hit_single_access: sdram_req=%b, required 0", bus.sdram_req);
      end
    end
    bus.slot_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic          got;
    logic [21:0]   exp_addr [5];
    logic [127:0]  exp_dout;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.slot_addr[0*AW +: AW] = 22'h200;
    bus.slot_addr[1*AW +: AW] = 22'h300;
    bus.slot_addr[2*AW +: AW] = 22'h010;
    bus.slot_addr[3*AW +: AW] = 22'h400;
    exp_addr[0] = 22'h200;
    exp_addr[1] = 22'h300;
`ifdef JTFRAME_ROM_ARB_PRIO_EN
    exp_addr[2] = 22'h310;
    exp_addr[3] = 22'h20010;
    exp_addr[4] = 22'h100400;
    exp_dout    = {32'hC0DE0004, 32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0000};
`else
    exp_addr[2] = 22'h20010;
    exp_addr[3] = 22'h100400;
    exp_addr[4] = 22'h310;
    exp_dout    = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0004, 32'hC0DE0000};
`endif
    bus.slot_req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_req(got);
      n_vec++;
      if (!got || bus.sdram_addr !== exp_addr[j]) begin
        n_err++;
        $display("FAIL rr_order_%0d: got=%b addr=%h, required 1/%h", j, got, bus.sdram_addr, exp_addr[j]);
      end
      if (got) respond(32'hC0DE0000 + 32'(j));
      if (j == 1) bus.slot_addr[1*AW +: AW] = 22'h310;
    end
    @(negedge clk);
    n_vec++;
    if (bus.slot_ok !== 4'b1111 || bus.slot_dout !== exp_dout) begin
      n_err++;
      $display("FAIL rr_final: ok=%b dout=%h, required 1111/%h", bus.slot_ok, bus.slot_dout, exp_dout);
    end
    n_vec++;
    if (bus.slot_dout[95:64] !== exp_dout[95:64]) begin
      n_err++;
      $display("FAIL rr_slot2_packing: dout2=%h, required %h", bus.slot_dout[95:64], exp_dout[95:64]);
    end
    bus.slot_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_download;
    logic got;
    bus.slot_addr[0*AW +: AW] = 22'h500;
    bus.slot_req = 4'b0001;
    wait_req(got);
    n_vec++;
    if (!got || bus.sdram_addr !== 22'h500) begin
      n_err++;
      $display("FAIL dl_first_req: got=%b addr=%h, required 1/500", got, bus.sdram_addr);
    end
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack   = 1'b0;
    bus.downloading = 1'b1;
    @(negedge clk);
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'h5555AAAA;
    @(negedge clk);
    bus.data_rdy = 1'b0;
    n_vec++;
    if (bus.slot_ok !== 4'b0000 || bus.slot_dout[31:0] !== 32'h5555AAAA) begin
      n_err++;
      $display("FAIL dl_discard: ok=%b dout0=%h, required 0000/5555aaaa", bus.slot_ok, bus.slot_dout[31:0]);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.sdram_req !== 1'b0) begin
        n_err++;
        $display("FAIL dl_block: sdram_req=%b, required 0", bus.sdram_req);
      end
    end
    bus.downloading = 1'b0;
    wait_req(got);
    n_vec++;
    if (!got || bus.sdram_addr !== 22'h500) begin
      n_err++;
      $display("FAIL dl_retry_req: got=%b addr=%h, required 1/500", got, bus.sdram_addr);
    end
    if (got) respond(32'h66667777);
    n_vec++;
    if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[31:0] !== 32'h66667777) begin
      n_err++;
      $display("FAIL dl_retry_data: ok0=%b dout0=%h, required 1/66667777",
               bus.slot_ok[0], bus.slot_dout[31:0]);
    end
    bus.slot_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_spurious;
    bus.sdram_ack = 1'b1;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'hBAD0BAD0;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.slot_dout[31:0] !== 32'h66667777 || bus.slot_ok[0] !== 1'b1 || bus.sdram_req !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_ignored: dout0=%h ok0=%b req=%b, required 66667777/1/0",
               bus.slot_dout[31:0], bus.slot_ok[0], bus.sdram_req);
    end
  endtask

  task automatic test_same_cycle;
    logic got;
    bus.slot_addr[0*AW +: AW] = 22'h600;
    bus.slot_req = 4'b0001;
    wait_req(got);
    n_vec++;
    if (!got || bus.sdram_addr !== 22'h600) begin
      n_err++;
      $display("FAIL same_req: got=%b addr=%h, required 1/600", got, bus.sdram_addr);
    end
    bus.sdram_ack = 1'b1;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'h12345678;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    n_vec++;
    if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[31:0] !== 32'h12345678 || bus.sdram_req !== 1'b0) begin
      n_err++;
      $display("FAIL same_data: ok0=%b dout0=%h req=%b, required 1/12345678/0",
               bus.slot_ok[0], bus.slot_dout[31:0], bus.sdram_req);
    end
    bus.slot_addr[0*AW +: AW] = 22'h601;
    @(negedge clk);
    n_vec++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h601) begin
      n_err++;
      $display("FAIL same_back_to_idle: req=%b addr=%h, required 1/601", bus.sdram_req, bus.sdram_addr);
    end
    if (bus.sdram_req === 1'b1) respond(32'h0000ABCD);
    bus.slot_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic got;
    bus.slot_addr[0*AW +: AW] = 22'h700;
    bus.slot_req = 4'b0001;
    wait_req(got);
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL arst_req: got=%b, required 1", got);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.sdram_req !== 1'b0 || bus.slot_ok !== 4'b0000 || bus.sdram_addr !== 22'h0 ||
        bus.slot_dout !== 128'd0) begin
      n_err++;
      $display("FAIL arst_immediate: req=%b ok=%b addr=%h dout=%h, required 0/0000/0/0",
               bus.sdram_req, bus.slot_ok, bus.sdram_addr, bus.slot_dout);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.slot_req = 4'b0000;
    @(negedge clk);
    n_vec++;
    if (bus.refresh_en !== 1'b1 || bus.sdram_req !== 1'b0) begin
      n_err++;
      $display("FAIL arst_recover: ref=%b req=%b, required 1/0", bus.refresh_en, bus.sdram_req);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst             = 1'b1;
    bus.downloading = 1'b0;
    bus.slot_req    = 4'b0000;
    bus.slot_addr   = '0;
    bus.sdram_ack   = 1'b0;
    bus.data_rdy    = 1'b0;
    bus.data_read   = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hit();
    test_round_robin();
    test_download();
    test_spurious();
    test_same_cycle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jtframe_rom_arb.md
Name: jtframe_rom_arb

Overview:
- Four-slot SDRAM read arbiter between the game's ROM consumers and the frame's single SDRAM read port (sdram_req/sdram_addr/sdram_ack/data_rdy/data_read).
- Each slot holds a one-entry cache: the last 32-bit word fetched and its address.
- Slot hits are answered with no SDRAM traffic. Misses are serialised onto the SDRAM port in round-robin order.
- Sits inside the game top, between the per-ROM address generators and the frame's SDRAM interface.

Parameters:
- AW, 22, width of slot and SDRAM word addresses.
- SLOT0_OFFSET, 22'h0, SDRAM base address added to slot 0 addresses; SLOT1_OFFSET..SLOT3_OFFSET likewise.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- downloading  input  1  ROM download in progress; blocks new grants.
- slot_req  input  4  per-slot level request, bit i = slot i.
- slot_addr  input  4*AW  packed slot addresses; slot i at [i*AW +: AW].
- slot_ok  output  4  slot_dout[i] is valid for the current slot_addr[i].
- slot_dout  output  128  packed cached words; slot i at [i*32 +: 32].
- sdram_req  output  1  request to SDRAM controller.
- sdram_addr  output  AW  request address: slot address plus offset.
- sdram_ack  input  1  one-cycle pulse; controller accepted the request.
- data_rdy  input  1  one-cycle pulse; data_read is valid.
- data_read  input  32  SDRAM read word.
- refresh_en  output  1  high when the arbiter permits SDRAM refresh.

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, slot_dout=0, all cache valid bits=0 (so slot_ok=0), refresh_en=0, state=IDLE, last_grant=3 (so slot 0 wins first).
- Hit: hit[i] = valid[i] & (cached_addr[i]==slot_addr[i]). This is combinational from registers; slot_ok = hit, independent of slot_req.
- Pending: pend = slot_req & ~hit.
- IDLE state:
  - If pend!=0 and !downloading: grant the first pending slot, searching from last_grant+1 upward with wrap 3->0.
  - On grant, register sel, lat_addr=slot_addr[sel], sdram_addr=slot_addr[sel]+SLOTsel_OFFSET (AW-bit wraparound add), sdram_req=1, last_grant=sel; go to WAIT_ACK.
  - Grant latency: pending seen in cycle N, sdram_req high in cycle N+1.
- WAIT_ACK state: hold sdram_req and sdram_addr stable until sdram_ack. On the ack cycle, sdram_req<=0 and go to WAIT_DATA.
- WAIT_DATA state: on data_rdy:
  - slot_dout[sel]<=data_read, cached_addr[sel]<=lat_addr.
  - valid[sel]<=1 unless the access is discarded (see below).
  - Return to IDLE. slot_ok rises the cycle after data_rdy if the address is unchanged.
  - A new grant may issue in the same cycle IDLE is re-entered, i.e. the cycle after data_rdy.
- Simultaneous sdram_ack and data_rdy in WAIT_ACK: treat as both events. Store the data and go directly to IDLE.
- Address changed during an access: data is still stored under lat_addr. slot_ok stays low and a new request follows.
- data_rdy or sdram_ack outside the expecting states: ignored.
- refresh_en = (state==IDLE) & (pend==0), registered.
- downloading:
  - While high, all valid bits are cleared every cycle and no grant issues.
  - If asserted mid-access, the transaction completes through the ack and data handshake, but valid[sel] is not set.
- Async rst mid-access: everything returns to reset values immediately. The SDRAM controller is reset by the same signal.
- No starvation: a continuously pending slot is granted within 4 accesses.

Optional Feature:
- Macro: JTFRAME_ROM_ARB_PRIO_EN.
- Defined: fixed priority, slot 0 highest and slot 3 lowest; last_grant is unused. Slot 3 may starve and this is accepted.
- Undefined: round-robin as described above.

Test Plan:
- Reset: after rst, slot_ok=0, sdram_req=0, refresh_en=1 within 1 cycle of idle. Then slot_req=4'b0001, addr0=22'h100, SLOT0_OFFSET=0 -> sdram_req=1, sdram_addr=22'h100 next cycle. Ack, then data_rdy with 32'hDEADBEEF -> slot_ok[0]=1, slot_dout[31:0]=32'hDEADBEEF.
- Hit: keep addr0=22'h100 and re-raise slot_req[0] -> no sdram_req, slot_ok[0] stays 1. Change addr0 to 22'h101 -> slot_ok[0]=0 and one new access.
- Round-robin: all four slots missing simultaneously -> grant order 0,1,2,3. With slot 1 re-missing after its grant, order continues 2,3 then 1.
- Offset and packing: SLOT2_OFFSET=22'h20000, addr2=22'h00010 -> sdram_addr=22'h20010, data lands in slot_dout[95:64].
- Download mid-access: assert downloading in WAIT_DATA -> data_rdy completes the access, slot_ok stays 0, no further sdram_req until downloading=0.
- Same-cycle ack and data_rdy -> data stored and arbiter back in IDLE the next cycle. With JTFRAME_ROM_ARB_PRIO_EN, all slots pending -> slot 0 granted repeatedly while it keeps missing.
